// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// ---------------
// Parametrised VGA timing and test-pattern generator. A pixel-rate enable
// (pix_en) is derived from CLOCK_50 by a divider; the horizontal and vertical
// counters advance on pix_en, and every output register is loaded from the
// decode of the counter values held before that pix_en. Sync, RGB, BLANK_N
// and PIX_X/Y therefore share one pixel period of latency.
//
// Ports:
//   CLOCK_50     in   system clock; all logic runs on it
//   RESET        in   asynchronous, active-high reset
//   MODE[1:0]    in   0 box, 1 colour bars, 2 checkerboard, 3 solid
//   COLOR[11:0]  in   {R,G,B} colour for box and solid modes
//   VGA_HS/VS    out  syncs, active level SYNC_POL
//   VGA_R/G/B    out  4-bit colour channels, 0 outside the active region
//   VGA_BLANK_N  out  high during the active region
//   PIX_X/PIX_Y  out  pixel column/line that the RGB outputs belong to
//   FRAME_START  out  one CLOCK_50 pulse on the update that shows pixel (0,0)
module vga_pattern_gen #(
    parameter int   H_VISIBLE  = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_VISIBLE  = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIX_DIV    = 2,
    parameter int   BOX_X0     = 200,
    parameter int   BOX_X1     = 299,
    parameter int   BOX_Y0     = 200,
    parameter int   BOX_Y1     = 299,
    parameter int   CHECK_LOG2 = 5
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [1:0]  MODE,
    input  logic [11:0] COLOR,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B,
    output logic        VGA_BLANK_N,
    output logic [11:0] PIX_X,
    output logic [11:0] PIX_Y,
    output logic        FRAME_START
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int BAR_W   = H_VISIBLE / 8;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
    localparam logic [11:0] HS_FIRST = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_LAST  = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_LAST  = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);
    localparam logic [11:0] BX0      = 12'(BOX_X0);
    localparam logic [11:0] BX1      = 12'(BOX_X1);
    localparam logic [11:0] BY0      = 12'(BOX_Y0);
    localparam logic [11:0] BY1      = 12'(BOX_Y1);

    // Registers
    logic [DIV_W-1:0] div_q, div_d;
    logic [11:0]      h_cnt_q, h_cnt_d;
    logic [11:0]      v_cnt_q, v_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [11:0]      color_q, color_d;
    logic [11:0]      bar_cnt_q, bar_cnt_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             blank_n_q, blank_n_d;
    logic [11:0]      pix_x_q, pix_x_d;
    logic [11:0]      pix_y_q, pix_y_d;
    logic             frame_start_q, frame_start_d;

    // Decode of the current counter position
    logic        pix_en;
    logic        h_wrap, v_wrap, origin;
    logic        h_act, v_act, active;
    logic        in_hs, in_vs, in_box, checker_on;
    logic [11:0] bar_rgb, pat_rgb;

    assign pix_en = (div_q == DIV_LAST);
    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);
    assign origin = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    assign h_act  = (h_cnt_q < H_VIS);
    assign v_act  = (v_cnt_q < V_VIS);
    assign active = h_act && v_act;
    assign in_hs  = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    assign in_vs  = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);
    assign in_box = (h_cnt_q >= BX0) && (h_cnt_q <= BX1) &&
                    (v_cnt_q >= BY0) && (v_cnt_q <= BY1);
    assign checker_on = h_cnt_q[CHECK_LOG2] ^ v_cnt_q[CHECK_LOG2];

    // Divider and position counters
    always_comb begin
        div_d   = pix_en ? '0 : div_q + 1'b1;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
            end
        end
    end

    // Mode/colour are only taken at the frame origin so a frame never mixes
    // two patterns. The pixel at (0,0) already uses the freshly sampled
    // values, hence the decode below works from mode_d/color_d.
    always_comb begin
        mode_d  = mode_q;
        color_d = color_q;
        if (pix_en && origin) begin
            mode_d  = MODE;
            color_d = COLOR;
        end
    end

    // Bar index tracks h_cnt with a running counter: it steps every BAR_W
    // active pixels and sticks at 7, so any remainder pixels when H_VISIBLE
    // is not a multiple of 8 stay in the last bar.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (pix_en) begin
            if (h_wrap) begin
                bar_cnt_d = 12'd0;
                bar_idx_d = 3'd0;
            end else if (h_act) begin
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = 12'd0;
                    bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 12'd1;
                end
            end
        end
    end

    always_comb begin
        case (bar_idx_q)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    always_comb begin
        pat_rgb = 12'h000;
        case (mode_d)
            2'd0:    pat_rgb = in_box ? color_d : 12'h000;
            2'd1:    pat_rgb = bar_rgb;
            2'd2:    pat_rgb = checker_on ? 12'hFFF : 12'h000;
            default: pat_rgb = color_d;
        endcase
        if (!active) begin
            pat_rgb = 12'h000;
        end
    end

    // Output registers: load on pix_en, hold otherwise. FRAME_START is the
    // only output that is not held; it lasts a single CLOCK_50 cycle.
    always_comb begin
        hs_d          = hs_q;
        vs_d          = vs_q;
        rgb_d         = rgb_q;
        blank_n_d     = blank_n_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_start_d = 1'b0;
        if (pix_en) begin
            hs_d          = in_hs ? SYNC_POL : ~SYNC_POL;
            vs_d          = in_vs ? SYNC_POL : ~SYNC_POL;
            rgb_d         = pat_rgb;
            blank_n_d     = active;
            pix_x_d       = h_cnt_q;
            pix_y_d       = v_cnt_q;
            frame_start_d = origin;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            div_q         <= '0;
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 12'd0;
            mode_q        <= 2'd0;
            color_q       <= 12'hFFF;
            bar_cnt_q     <= 12'd0;
            bar_idx_q     <= 3'd0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            rgb_q         <= 12'h000;
            blank_n_q     <= 1'b0;
            pix_x_q       <= 12'd0;
            pix_y_q       <= 12'd0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            mode_q        <= mode_d;
            color_q       <= color_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            rgb_q         <= rgb_d;
            blank_n_q     <= blank_n_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_R       = rgb_q[11:8];
    assign VGA_G       = rgb_q[7:4];
    assign VGA_B       = rgb_q[3:0];
    assign VGA_BLANK_N = blank_n_q;
    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen with a reduced display mode so several whole
// frames fit in a short run. Position, sync, colour and frame markers are
// predicted from the count of CLOCK_50 edges since reset release.
module tb_vga_pattern_gen;

    localparam int   HV  = 64;
    localparam int   HF  = 4;
    localparam int   HSW = 8;
    localparam int   HB  = 4;
    localparam int   VV  = 24;
    localparam int   VF  = 2;
    localparam int   VSW = 2;
    localparam int   VB  = 2;
    localparam logic SP  = 1'b0;
    localparam int   PD  = 2;
    localparam int   BX0 = 10;
    localparam int   BX1 = 19;
    localparam int   BY0 = 5;
    localparam int   BY1 = 14;
    localparam int   CL  = 2;

    localparam int HT    = HV + HF + HSW + HB;
    localparam int VT    = VV + VF + VSW + VB;
    localparam int FRAME = HT * VT * PD;
    localparam int BAR_W = HV / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode_in = 2'd0;
    logic [11:0] color_in = 12'hF00;
    logic        vga_hs, vga_vs, vga_blank_n, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [11:0] pix_x, pix_y;

    vga_pattern_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .SYNC_POL(SP), .PIX_DIV(PD),
        .BOX_X0(BX0), .BOX_X1(BX1), .BOX_Y0(BY0), .BOX_Y1(BY1),
        .CHECK_LOG2(CL)
    ) dut (
        .CLOCK_50(clk),
        .RESET(rst),
        .MODE(mode_in),
        .COLOR(color_in),
        .VGA_HS(vga_hs),
        .VGA_VS(vga_vs),
        .VGA_R(vga_r),
        .VGA_G(vga_g),
        .VGA_B(vga_b),
        .VGA_BLANK_N(vga_blank_n),
        .PIX_X(pix_x),
        .PIX_Y(pix_y),
        .FRAME_START(frame_start)
    );

    always #5 clk = ~clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc = 0;
    longint      tick = 0;
    longint      last_fs_tick = 0;
    bit          have_fs = 1'b0;
    int          m_mode = 0;
    logic [11:0] m_color = 12'hFFF;
    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int x, input int y,
                                            input int md, input logic [11:0] c);
        int bi;
        if (x >= HV || y >= VV) return 12'h000;
        case (md)
            0: return (x >= BX0 && x <= BX1 && y >= BY0 && y <= BY1) ? c : 12'h000;
            1: begin
                bi = x / BAR_W;
                if (bi > 7) bi = 7;
                return bar_tab[bi];
            end
            2: return ((((x >> CL) ^ (y >> CL)) & 1) == 1) ? 12'hFFF : 12'h000;
            default: return c;
        endcase
    endfunction

    function automatic int cur_x();
        return ((cyc / PD) - 1) % HT;
    endfunction

    function automatic int cur_y();
        return (((cyc / PD) - 1) / HT) % VT;
    endfunction

    // One CLOCK_50 cycle: advance the model and compare all outputs.
    task automatic step();
        int x, y;
        logic hs_e, vs_e, act;
        @(posedge clk);
        #1;
        tick++;
        cyc++;
        if (cyc % PD == 0) begin
            x = cur_x();
            y = cur_y();
            if (x == 0 && y == 0) begin
                m_mode  = int'(mode_in);
                m_color = color_in;
            end
            hs_e = (x >= HV + HF && x < HV + HF + HSW) ? SP : ~SP;
            vs_e = (y >= VV + VF && y < VV + VF + VSW) ? SP : ~SP;
            act  = (x < HV) && (y < VV);
            check_eq("pix_xy", {8'd0, pix_x, pix_y}, {8'd0, 12'(x), 12'(y)});
            check_eq("sync", {30'd0, vga_hs, vga_vs}, {30'd0, hs_e, vs_e});
            check_eq("rgb_blank", {19'd0, vga_blank_n, vga_r, vga_g, vga_b},
                     {19'd0, act, exp_rgb(x, y, m_mode, m_color)});
            check_eq("frame_start", 32'(frame_start), 32'(x == 0 && y == 0));
        end else begin
            check_eq("frame_start_idle", 32'(frame_start), 32'd0);
        end
        if (frame_start) begin
            if (have_fs) check_eq("frame_period", 32'(tick - last_fs_tick), 32'(FRAME));
            last_fs_tick = tick;
            have_fs = 1'b1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_sync"}, {30'd0, vga_hs, vga_vs}, {30'd0, ~SP, ~SP});
        check_eq({tag, "_rgb_blank"}, {19'd0, vga_blank_n, vga_r, vga_g, vga_b}, 32'd0);
        check_eq({tag, "_pix"}, {8'd0, pix_x, pix_y}, 32'd0);
        check_eq({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    // Release reset between edges and measure the delay to the first
    // FRAME_START pulse.
    task automatic release_reset();
        int n;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        have_fs = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < 4 * PD);
        check_eq("first_fs_latency", 32'(n), 32'(PD));
    endtask

    // Run to pixel (xt,yt) of the next frame, then assert reset away from
    // any clock edge and check the outputs before the next edge arrives.
    task automatic reset_at(input int xt, input int yt, input string tag);
        int  n;
        bit  seen_fs, found;
        n = 0;
        seen_fs = 1'b0;
        found = 1'b0;
        while (!found && n < 3 * FRAME) begin
            step();
            n++;
            if (frame_start) seen_fs = 1'b1;
            else if (seen_fs && cyc % PD == 0 && cur_x() == xt && cur_y() == yt)
                found = 1'b1;
        end
        check_eq({tag, "_target_reached"}, 32'(found), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals({tag, "_async"});
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals({tag, "_held"});
        release_reset();
    endtask

    initial begin
        int off;
        if (HT > 4095 || VT > 4095) begin
            $display("FAIL param_range: H_TOTAL %0d V_TOTAL %0d exceed 4095", HT, VT);
            $fatal(1);
        end

        #1 rst = 1'b1;
        #2;
        check_reset_vals("por");
        mode_in  = 2'd0;
        color_in = 12'hF00;
        repeat (2) @(posedge clk);
        release_reset();

        // Mid-frame mode/colour changes: first walk all four modes in order,
        // then random ones; each change lands at a random point of a frame.
        for (int f = 0; f < 6; f++) begin
            off = int'($urandom_range(FRAME / 4, 3 * FRAME / 4));
            for (int k = 0; k < FRAME; k++) begin
                step();
                if (k == off) begin
                    mode_in  = (f < 4) ? 2'((f + 1) % 4) : 2'($urandom_range(0, 3));
                    color_in = 12'($urandom_range(0, 4095));
                end
            end
        end

        // Reset inside a visible solid-colour line, so RGB is non-zero.
        mode_in  = 2'd3;
        color_in = 12'($urandom_range(1, 4095)) | 12'h100;
        reset_at(20, VV / 2, "rst_visible");

        // Reset while HS is active.
        mode_in  = 2'($urandom_range(0, 3));
        color_in = 12'($urandom_range(0, 4095));
        reset_at(HV + HF + 2, VV / 2, "rst_hsync");

        for (int k = 0; k < FRAME + 4 * PD; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
